// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour types and the RRR_GGG_BB to 4:4:4 expansion helper.
package vga_pkg;

  localparam int unsigned H_ACTIVE   = 640;
  localparam int unsigned H_FP       = 16;
  localparam int unsigned H_SYNC     = 96;
  localparam int unsigned H_BP       = 48;
  localparam int unsigned V_ACTIVE   = 480;
  localparam int unsigned V_FP       = 10;
  localparam int unsigned V_SYNC     = 2;
  localparam int unsigned V_BP       = 33;
  localparam int unsigned NUM_LAYERS = 4;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  typedef logic [7:0] rgb332_t;

  typedef struct packed {
    logic [3:0] R;
    logic [3:0] G;
    logic [3:0] B;
  } rgb444_t;

  localparam rgb332_t BG_RGB = 8'h00;

  // Replicate the top bits so full-scale 3/2-bit values map to full-scale 4-bit DAC codes.
  function automatic rgb444_t expand_rgb332(input rgb332_t c);
    rgb444_t o;
    o.R = {c[7:5], c[7]};
    o.G = {c[4:2], c[4]};
    o.B = {c[1:0], c[1:0]};
    return o;
  endfunction

endpackage

// File: rtl/vga_timing_mixer_if.sv
// Pixel coordinate / drawing-request bus between the timing mixer and the screen objects.
interface vga_timing_mixer_if #(
  parameter int unsigned NUM_LAYERS = vga_pkg::NUM_LAYERS
);

  logic [9:0]              pixel_x;
  logic [9:0]              pixel_y;
  logic                    pixel_en;
  logic                    startOfFrame;
  logic [NUM_LAYERS-1:0]   draw_req;
  logic [8*NUM_LAYERS-1:0] layer_rgb;

  modport master (
    output pixel_x,
    output pixel_y,
    output pixel_en,
    output startOfFrame,
    input  draw_req,
    input  layer_rgb
  );

  modport slave (
    input  pixel_x,
    input  pixel_y,
    input  pixel_en,
    input  startOfFrame,
    output draw_req,
    output layer_rgb
  );

endinterface

// File: rtl/vga_layer_priority_mux.sv
// Fixed-priority colour select across drawing layers; layer 0 wins, background when nobody draws.
module vga_layer_priority_mux
  import vga_pkg::rgb332_t;
#(
  parameter int unsigned NUM_LAYERS = 4
) (
  input  logic [NUM_LAYERS-1:0]   draw_req,
  input  logic [8*NUM_LAYERS-1:0] layer_rgb,
  input  rgb332_t                 bg_rgb,
  output rgb332_t                 rgb
);

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    rgb = bg_rgb;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (draw_req[NUM_LAYERS-1-i]) begin
        rgb = layer_rgb[8*(NUM_LAYERS-1-i) +: 8];
      end
    end
  end

endmodule

// File: rtl/vga_timing_mixer.sv
// VGA timing generator plus layer mixer: drives pixel coordinates out, resolves layer colours back
// and registers them together with HS/VS so sync stays aligned with colour at the pins.
module vga_timing_mixer
  import vga_pkg::rgb332_t, vga_pkg::rgb444_t, vga_pkg::expand_rgb332;
#(
  parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP       = vga_pkg::H_FP,
  parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
  parameter int unsigned H_BP       = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP       = vga_pkg::V_FP,
  parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
  parameter int unsigned V_BP       = vga_pkg::V_BP,
  parameter int unsigned NUM_LAYERS = vga_pkg::NUM_LAYERS,
  parameter rgb332_t     BG_RGB     = vga_pkg::BG_RGB
) (
  input  logic                      CLK_50,
  input  logic                      resetN,
  vga_timing_mixer_if.master        pix,
  output logic                      VGA_HS,
  output logic                      VGA_VS,
  output logic [3:0]                VGA_R,
  output logic [3:0]                VGA_G,
  output logic [3:0]                VGA_B
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       pixel_en_q;
  logic [9:0] x_q;
  logic [9:0] y_q;
  logic       x_last;
  logic       y_last;

  assign x_last = (x_q == X_LAST);
  assign y_last = (y_q == Y_LAST);

  // Pixel clock is CLK_50/2; pixel_en marks the second half of each pixel period.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      pixel_en_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      pixel_en_q <= ~pixel_en_q;
      if (pixel_en_q) begin
        if (x_last) begin
          x_q <= '0;
          y_q <= y_last ? '0 : y_q + 10'd1;
        end else begin
          x_q <= x_q + 10'd1;
        end
      end
    end
  end

  assign pix.pixel_x      = x_q;
  assign pix.pixel_y      = y_q;
  assign pix.pixel_en     = pixel_en_q;
  assign pix.startOfFrame = pixel_en_q && x_last && y_last;

  rgb332_t layer_pick;

  vga_layer_priority_mux #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_priority_mux (
    .draw_req  (pix.draw_req),
    .layer_rgb (pix.layer_rgb),
    .bg_rgb    (BG_RGB),
    .rgb       (layer_pick)
  );

  logic    active;
  logic    hs_n;
  logic    vs_n;
  rgb332_t pix_rgb;
  rgb444_t pix_444;

  // Sync is decoded from the same x/y the clients answered for, keeping it aligned with colour.
  always_comb begin
    active  = (x_q < X_ACT) && (y_q < Y_ACT);
    hs_n    = !((x_q >= HS_START) && (x_q < HS_END));
    vs_n    = !((y_q >= VS_START) && (y_q < VS_END));
    pix_rgb = active ? layer_pick : '0;
    pix_444 = expand_rgb332(pix_rgb);
  end

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
    end else if (pixel_en_q) begin
      VGA_HS <= hs_n;
      VGA_VS <= vs_n;
      VGA_R  <= pix_444.R;
      VGA_G  <= pix_444.G;
      VGA_B  <= pix_444.B;
    end
  end

endmodule

// File: tb/tb_vga_timing_mixer.sv
// Directed bench: full 640x480 instance for line timing and colour mixing, reduced-geometry
// instance (50x30 total) for frame timing, vertical blanking and mid-frame reset.
module tb_vga_timing_mixer;

  logic CLK_50 = 1'b0;
  logic rst_full_n;
  logic rst_small_n;

  always #10 CLK_50 = ~CLK_50;

  vga_timing_mixer_if #(.NUM_LAYERS(4)) pf ();
  vga_timing_mixer_if #(.NUM_LAYERS(4)) ps ();

  logic       hs_f, vs_f, hs_s, vs_s;
  logic [3:0] r_f, g_f, b_f, r_s, g_s, b_s;

  vga_timing_mixer #(
    .NUM_LAYERS (4),
    .BG_RGB     (8'h03)
  ) dut_full (
    .CLK_50 (CLK_50),
    .resetN (rst_full_n),
    .pix    (pf),
    .VGA_HS (hs_f),
    .VGA_VS (vs_f),
    .VGA_R  (r_f),
    .VGA_G  (g_f),
    .VGA_B  (b_f)
  );

  vga_timing_mixer #(
    .H_ACTIVE   (32),
    .H_FP       (4),
    .H_SYNC     (8),
    .H_BP       (6),
    .V_ACTIVE   (20),
    .V_FP       (3),
    .V_SYNC     (2),
    .V_BP       (5),
    .NUM_LAYERS (4),
    .BG_RGB     (8'h00)
  ) dut_small (
    .CLK_50 (CLK_50),
    .resetN (rst_small_n),
    .pix    (ps),
    .VGA_HS (hs_s),
    .VGA_VS (vs_s),
    .VGA_R  (r_s),
    .VGA_G  (g_s),
    .VGA_B  (b_s)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Return at the negedge where the full DUT shows (x,y) in the sampling half of the pixel.
  task automatic wait_full(input logic [9:0] x, input logic [9:0] y);
    int unsigned k = 0;
    while (!(pf.pixel_x === x && pf.pixel_y === y && pf.pixel_en === 1'b1) && k < 40000) begin
      @(negedge CLK_50);
      k++;
    end
    checks++;
    assert (k < 40000) else begin
      errors++;
      $error("FAIL wait_full: timeout observed %0d cycles expected < 40000", k);
    end
  endtask

  task automatic wait_small(input logic [9:0] x, input logic [9:0] y);
    int unsigned k = 0;
    while (!(ps.pixel_x === x && ps.pixel_y === y && ps.pixel_en === 1'b1) && k < 8000) begin
      @(negedge CLK_50);
      k++;
    end
    checks++;
    assert (k < 8000) else begin
      errors++;
      $error("FAIL wait_small: timeout observed %0d cycles expected < 8000", k);
    end
  endtask

  initial begin
    rst_full_n   = 1'b0;
    rst_small_n  = 1'b0;
    pf.draw_req  = '0;
    pf.layer_rgb = '0;
    ps.draw_req  = '0;
    ps.layer_rgb = '0;
    @(negedge CLK_50);
    @(negedge CLK_50);

    // Reset state
    check("rst_x",   32'(pf.pixel_x), 32'd0);
    check("rst_y",   32'(pf.pixel_y), 32'd0);
    check("rst_pen", 32'(pf.pixel_en), 32'd0);
    check("rst_sof", 32'(pf.startOfFrame), 32'd0);
    check("rst_hs",  32'(hs_f), 32'd1);
    check("rst_vs",  32'(vs_f), 32'd1);
    check("rst_rgb", 32'({r_f, g_f, b_f}), 32'h000);

    rst_full_n  = 1'b1;
    rst_small_n = 1'b1;
    @(negedge CLK_50);
    check("rel1_pen", 32'(pf.pixel_en), 32'd1);
    check("rel1_x",   32'(pf.pixel_x), 32'd0);
    check("rel1_rgb", 32'({r_f, g_f, b_f}), 32'h000);
    check("rel1_hs",  32'(hs_f), 32'd1);
    @(negedge CLK_50);
    check("rel2_x",   32'(pf.pixel_x), 32'd1);
    check("rel2_y",   32'(pf.pixel_y), 32'd0);
    check("rel2_pen", 32'(pf.pixel_en), 32'd0);
    check("rel2_bg",  32'({r_f, g_f, b_f}), 32'h00F);

    // Line timing: HS falls one pixel after x=656, low 192 cycles, 1600-cycle line
    wait_full(10'd656, 10'd0);
    check("hs_before", 32'(hs_f), 32'd1);
    @(negedge CLK_50);
    check("hs_fall",   32'(hs_f), 32'd0);
    check("hs_fall_x", 32'(pf.pixel_x), 32'd657);
    n = 0;
    while (hs_f === 1'b0 && n < 4000) begin
      n++;
      @(negedge CLK_50);
    end
    check("hs_width", n, 32'd192);
    while (hs_f === 1'b1 && n < 4000) begin
      n++;
      @(negedge CLK_50);
    end
    check("line_period", n, 32'd1600);

    // Priority: layer1 beats layer2, X on unrequested layer0 ignored
    wait_full(10'd10, 10'd10);
    pf.draw_req  = 4'b0110;
    pf.layer_rgb = {8'hFF, 8'h1C, 8'hE0, 8'hxx};
    @(negedge CLK_50);
    check("prio_l1", 32'({r_f, g_f, b_f}), 32'hF00);
    pf.draw_req  = 4'b0000;
    pf.layer_rgb = {4{8'hxx}};

    wait_full(10'd20, 10'd10);
    @(negedge CLK_50);
    check("bg_03", 32'({r_f, g_f, b_f}), 32'h00F);

    wait_full(10'd30, 10'd10);
    pf.draw_req  = 4'b1001;
    pf.layer_rgb = {8'h1C, 8'h00, 8'h00, 8'hA9};
    @(negedge CLK_50);
    check("prio_l0", 32'({r_f, g_f, b_f}), 32'hB45);

    wait_full(10'd40, 10'd10);
    pf.draw_req  = 4'b1000;
    @(negedge CLK_50);
    check("prio_l3", 32'({r_f, g_f, b_f}), 32'h0F0);

    // Horizontal active/blank boundary
    wait_full(10'd639, 10'd10);
    pf.draw_req  = 4'b0001;
    pf.layer_rgb = {24'h0, 8'hFF};
    @(negedge CLK_50);
    check("x639_white", 32'({r_f, g_f, b_f}), 32'hFFF);
    @(negedge CLK_50);
    @(negedge CLK_50);
    check("x640_blank", 32'({r_f, g_f, b_f}), 32'h000);

    wait_full(10'd700, 10'd10);
    pf.draw_req  = 4'b1111;
    @(negedge CLK_50);
    check("x700_blank", 32'({r_f, g_f, b_f}), 32'h000);
    check("x700_hs",    32'(hs_f), 32'd0);
    pf.draw_req  = 4'b0000;

    // Reduced geometry: vertical boundary and blanking
    wait_small(10'd5, 10'd19);
    ps.draw_req  = 4'b0001;
    ps.layer_rgb = {24'h0, 8'hFF};
    @(negedge CLK_50);
    check("y19_white", 32'({r_s, g_s, b_s}), 32'hFFF);
    ps.draw_req  = 4'b0000;
    wait_small(10'd5, 10'd20);
    ps.draw_req  = 4'b1111;
    @(negedge CLK_50);
    check("y20_blank", 32'({r_s, g_s, b_s}), 32'h000);
    ps.draw_req  = 4'b0000;

    // VS falls one pixel after y=23 begins, low for 2 lines of 100 cycles
    wait_small(10'd0, 10'd23);
    check("vs_before", 32'(vs_s), 32'd1);
    @(negedge CLK_50);
    check("vs_fall", 32'(vs_s), 32'd0);
    n = 0;
    while (vs_s === 1'b0 && n < 8000) begin
      n++;
      @(negedge CLK_50);
    end
    check("vs_width", n, 32'd200);

    // startOfFrame: single cycle at (49,29), period 3000 cycles
    n = 0;
    while (ps.startOfFrame !== 1'b1 && n < 8000) begin
      n++;
      @(negedge CLK_50);
    end
    check("sof_seen", 32'(ps.startOfFrame), 32'd1);
    check("sof_x",    32'(ps.pixel_x), 32'd49);
    check("sof_y",    32'(ps.pixel_y), 32'd29);
    check("sof_pen",  32'(ps.pixel_en), 32'd1);
    @(negedge CLK_50);
    check("sof_drop", 32'(ps.startOfFrame), 32'd0);
    check("wrap_xy",  32'({ps.pixel_x, ps.pixel_y}), 32'd0);
    n = 1;
    while (ps.startOfFrame !== 1'b1 && n < 8000) begin
      @(negedge CLK_50);
      n++;
    end
    check("sof_period", n, 32'd3000);

    // Mid-frame reset
    wait_small(10'd30, 10'd12);
    ps.draw_req  = 4'b0001;
    ps.layer_rgb = {24'h0, 8'hFF};
    @(negedge CLK_50);
    check("pre_rst_rgb", 32'({r_s, g_s, b_s}), 32'hFFF);
    rst_small_n = 1'b0;
    #1;
    check("mrst_xy",  32'({ps.pixel_x, ps.pixel_y}), 32'd0);
    check("mrst_pen", 32'(ps.pixel_en), 32'd0);
    check("mrst_sof", 32'(ps.startOfFrame), 32'd0);
    check("mrst_sync", 32'({hs_s, vs_s}), 32'd3);
    check("mrst_rgb", 32'({r_s, g_s, b_s}), 32'h000);
    repeat (3) @(negedge CLK_50);
    check("mrst_hold_x", 32'(ps.pixel_x), 32'd0);
    rst_small_n = 1'b1;
    ps.draw_req = 4'b0000;
    @(negedge CLK_50);
    check("mrel_pen", 32'(ps.pixel_en), 32'd1);
    check("mrel_xy",  32'({ps.pixel_x, ps.pixel_y}), 32'd0);
    n = 1;
    while (ps.startOfFrame !== 1'b1 && n < 8000) begin
      @(negedge CLK_50);
      n++;
    end
    check("mrel_first_sof", n, 32'd2999);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
